regfile_access_sequencer: RTL

//  Initiator side of the single-port register-file interface (sel/mode/data_in/data_out).

---
 rtl/regfile_access_sequencer_pkg.sv | 56 +++++
 rtl/regfile_access_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/regfile_access_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_access_sequencer_pkg
// Brief   : Shared register-file port mode codes, sequencer state encoding
//           and the state-ordering helper for regfile_access_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_access_sequencer_pkg;

    // Register-file port modes
    localparam logic [1:0] c_mode_nop = 2'b00;
    localparam logic [1:0] c_mode_in  = 2'b01;  // write data_in into sel
    localparam logic [1:0] c_mode_out = 2'b10;  // read sel onto data_out

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD_A = 3'd2,
        ST_RD_B = 3'd3,
        ST_CAP  = 3'd4,
        ST_RESP = 3'd5
    } seq_state_t;

    // Fixed walk IDLE->WR->RD_A->RD_B->CAP->RESP, skipping what the bundle
    // does not request; CAP only follows an issued read.
    function automatic seq_state_t seq_next(input seq_state_t cur,
                                            input logic wr,
                                            input logic rd_a,
                                            input logic rd_b);
        seq_state_t nxt;
        nxt = ST_IDLE;
        case (cur)
            ST_IDLE: nxt = wr   ? ST_WR   : rd_a ? ST_RD_A : rd_b ? ST_RD_B : ST_RESP;
            ST_WR:   nxt = rd_a ? ST_RD_A : rd_b ? ST_RD_B : ST_RESP;
            ST_RD_A: nxt = rd_b ? ST_RD_B : ST_CAP;
            ST_RD_B: nxt = ST_CAP;
            ST_CAP:  nxt = ST_RESP;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    // Port mode driven while in a given state
    function automatic logic [1:0] seq_mode(input seq_state_t st);
        logic [1:0] m;
        m = c_mode_nop;
        case (st)
            ST_WR:           m = c_mode_in;
            ST_RD_A, ST_RD_B: m = c_mode_out;
            default:         m = c_mode_nop;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : regfile_access_sequencer
// Brief   : Serialises one decode access bundle (optional write-back, up to
//           two operand reads) onto the single register-file port and returns
//           both operands in one response.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_access_sequencer
    import regfile_access_sequencer_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_rd_a,
    input  logic              req_rd_b,
    input  logic [ADDR_W-1:0] req_sel_d,
    input  logic [ADDR_W-1:0] req_sel_a,
    input  logic [ADDR_W-1:0] req_sel_b,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_op_a,
    output logic [WIDTH-1:0]  rsp_op_b,
    output logic [ADDR_W-1:0] rf_sel,
    output logic [1:0]        rf_mode,
    output logic [WIDTH-1:0]  rf_wdata,
    input  logic [WIDTH-1:0]  rf_rdata
);

    seq_state_t        r_state;
    logic              r_rd_a;
    logic              r_rd_b;
    logic [ADDR_W-1:0] r_sel_a;
    logic [ADDR_W-1:0] r_sel_b;

    // WR can only follow IDLE, so the write-back target and data are taken
    // straight from the request; read fields are latched for later states.
    logic              w_is_idle;
    logic              w_rd_a;
    logic              w_rd_b;
    logic [ADDR_W-1:0] w_sel_a;
    logic [ADDR_W-1:0] w_sel_b;
    logic              w_advance;
    seq_state_t        w_next;

    assign w_is_idle = (r_state == ST_IDLE);
    assign w_rd_a    = w_is_idle ? req_rd_a  : r_rd_a;
    assign w_rd_b    = w_is_idle ? req_rd_b  : r_rd_b;
    assign w_sel_a   = w_is_idle ? req_sel_a : r_sel_a;
    assign w_sel_b   = w_is_idle ? req_sel_b : r_sel_b;
    assign w_next    = seq_next(r_state, req_wr, w_rd_a, w_rd_b);

    // IDLE waits for a bundle, RESP for the consumer; every other state lasts one cycle
    always_comb begin
        w_advance = 1'b1;
        case (r_state)
            ST_IDLE: w_advance = req_valid;
            ST_RESP: w_advance = rsp_ready;
            default: w_advance = 1'b1;
        endcase
    end

    // Sequencer state, latched bundle, operand capture and registered port outputs
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state   <= ST_IDLE;
            r_rd_a    <= 1'b0;
            r_rd_b    <= 1'b0;
            r_sel_a   <= '0;
            r_sel_b   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_op_a  <= '0;
            rsp_op_b  <= '0;
            rf_sel    <= '0;
            rf_mode   <= c_mode_nop;
            rf_wdata  <= '0;
        end else begin
            if (w_is_idle && req_valid) begin
                r_rd_a   <= req_rd_a;
                r_rd_b   <= req_rd_b;
                r_sel_a  <= req_sel_a;
                r_sel_b  <= req_sel_b;
                rsp_op_a <= '0;
                rsp_op_b <= '0;
            end

            // Read data trails its Out cycle by one: A lands during RD_B,
            // the final read lands during CAP.
            if (r_state == ST_RD_B && r_rd_a) begin
                rsp_op_a <= rf_rdata;
            end
            if (r_state == ST_CAP) begin
                if (r_rd_b) begin
                    rsp_op_b <= rf_rdata;
                end else begin
                    rsp_op_a <= rf_rdata;
                end
            end

            if (w_advance) begin
                r_state   <= w_next;
                rf_mode   <= seq_mode(w_next);
                req_ready <= (w_next == ST_IDLE);
                rsp_valid <= (w_next == ST_RESP);
                case (w_next)
                    ST_WR: begin
                        rf_sel   <= req_sel_d;
                        rf_wdata <= req_wdata;
                    end
                    ST_RD_A: rf_sel <= w_sel_a;
                    ST_RD_B: rf_sel <= w_sel_b;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
